// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage and IF/ID pipeline register
// One outstanding imem request, a 1-entry skid buffer, redirect flush and a saturating stall counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   keep_PC,
  input  logic                   keep_instr,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr_ID,
  output logic [31:0]            pc_ID,
  output logic                   valid_ID,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc;
  logic        drop;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic ack_w, buf_fill, direct_load, issue;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // A response headed for the skid buffer also blocks issue, so the buffer can never overflow.
  always_comb begin
    state_next  = state;
    ack_w       = (state == S_WAIT) && imem_ack;
    buf_fill    = ack_w && !drop && !redirect_valid && (keep_instr || buf_valid);
    direct_load = ack_w && !drop && !redirect_valid && !keep_instr && !buf_valid;
    issue       = !buf_valid && !buf_fill && !keep_PC && !redirect_valid &&
                  ((state == S_IDLE) || ack_w);
    if (issue)      state_next = S_WAIT;
    else if (ack_w) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      drop      <= 1'b0;
      buf_valid <= 1'b0;
      buf_instr <= 32'h0;
      buf_pc    <= 32'h0;
    end else begin
      if (issue) begin
        imem_req  <= 1'b1;
        imem_addr <= fetch_pc;
        fetch_pc  <= fetch_pc + 32'd4;
      end else if (ack_w) begin
        imem_req  <= 1'b0;
      end
      if (redirect_valid) fetch_pc <= redirect_pc;

      // The in-flight response of a redirected request must never reach IF/ID.
      if (redirect_valid && (state == S_WAIT) && !imem_ack) drop <= 1'b1;
      else if (ack_w)                                       drop <= 1'b0;

      if (redirect_valid) begin
        buf_valid <= 1'b0;
      end else if (buf_fill) begin
        buf_valid <= 1'b1;
        buf_instr <= imem_rdata;
        buf_pc    <= imem_addr;
      end else if (!keep_instr) begin
        buf_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ID <= NOP_INSTR;
      pc_ID    <= 32'h0;
      valid_ID <= 1'b0;
    end else if (redirect_valid) begin
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
    end else if (!keep_instr) begin
      if (buf_valid) begin
        instr_ID <= buf_instr;
        pc_ID    <= buf_pc;
        valid_ID <= 1'b1;
      end else if (direct_load) begin
        instr_ID <= imem_rdata;
        pc_ID    <= imem_addr;
        valid_ID <= 1'b1;
      end else begin
        instr_ID <= NOP_INSTR;
        valid_ID <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (keep_instr && valid_ID && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Memory model + scoreboard of expected fetch addresses, checked as instructions land in IF/ID.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, keep_PC, keep_instr, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_ID, pc_ID;
  logic        valid_ID;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] sb[$];
  logic [31:0] model_pc;
  logic        model_drop;
  int          mem_delay;
  int          wait_cnt;
  logic        man_en, man_ack;

  fetch_unit dut (
    .clk(clk), .rst(rst), .keep_PC(keep_PC), .keep_instr(keep_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_ID(instr_ID), .pc_ID(pc_ID), .valid_ID(valid_ID), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic model_loop();
    logic ki_q, rv_q, rst_q, req_q, ack_q;
    logic [31:0] addr_q, e;
    forever begin
      @(posedge clk);
      ki_q = keep_instr; rv_q = redirect_valid; rst_q = rst;
      req_q = imem_req; ack_q = imem_ack; addr_q = imem_addr;
      #1;
      if (!rst_q) begin
        if (req_q && !ack_q) begin
          tests++;
          if (imem_req !== 1'b1 || imem_addr !== addr_q) begin
            fails++;
            $display("FAIL addr_hold: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, addr_q);
          end
        end
        if (rv_q) begin
          tests++;
          if (valid_ID !== 1'b0 || instr_ID !== NOP) begin
            fails++;
            $display("FAIL redirect_bubble: valid=%b instr=%h want 0/%h", valid_ID, instr_ID, NOP);
          end
        end else if (!ki_q) begin
          tests++;
          if (valid_ID === 1'b1) begin
            if (sb.size() == 0) begin
              fails++;
              $display("FAIL ifid_unexpected: pc_ID=%h instr=%h want no instruction", pc_ID, instr_ID);
            end else begin
              e = sb.pop_front();
              if (pc_ID !== e || instr_ID !== word_of(e)) begin
                fails++;
                $display("FAIL ifid_stream: pc=%h instr=%h want pc=%h instr=%h", pc_ID, instr_ID, e, word_of(e));
              end
            end
          end else if (instr_ID !== NOP || valid_ID !== 1'b0) begin
            fails++;
            $display("FAIL bubble: valid=%b instr=%h want 0/%h", valid_ID, instr_ID, NOP);
          end
        end
      end
      @(negedge clk);
      #1;
      if (man_en) begin
        imem_ack = man_ack; imem_rdata = word_of(imem_addr); wait_cnt = 0;
      end else if (!rst && imem_req) begin
        if (wait_cnt >= mem_delay) begin
          imem_ack = 1'b1; imem_rdata = word_of(imem_addr); wait_cnt = 0;
        end else begin
          imem_ack = 1'b0; wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0; wait_cnt = 0;
      end
      if (rst) begin
        model_pc = 32'h0; model_drop = 1'b0; sb.delete();
      end else if (redirect_valid) begin
        sb.delete(); model_pc = redirect_pc;
        model_drop = imem_req && !imem_ack;
      end else if (imem_req && imem_ack) begin
        if (model_drop) model_drop = 1'b0;
        else begin
          tests++;
          if (imem_addr !== model_pc) begin
            fails++;
            $display("FAIL fetch_addr: imem_addr=%h want %h", imem_addr, model_pc);
          end
          sb.push_back(model_pc);
          model_pc = model_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_ID !== NOP || pc_ID !== 32'h0 ||
        valid_ID !== 1'b0 || stall_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: req=%b addr=%h instr=%h pc=%h valid=%b cnt=%h want 0/0/%h/0/0/0",
               imem_req, imem_addr, instr_ID, pc_ID, valid_ID, stall_cnt, NOP);
    end
  endtask

  task automatic test_zero_wait();
    @(negedge clk); mem_delay = 0; rst = 1'b0; keep_PC = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i <= 3) begin
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i - 1))) begin
          fails++;
          $display("FAIL zw_addr: cycle %0d req=%b addr=%h want 1/%h", i, imem_req, imem_addr, 4 * (i - 1));
        end
      end
      tests++;
      if (valid_ID !== (i >= 2)) begin
        fails++;
        $display("FAIL zw_valid: cycle %0d valid=%b want %b", i, valid_ID, i >= 2);
      end
      if (i == 2) begin
        tests++;
        if (instr_ID !== word_of(32'h0) || pc_ID !== 32'h0) begin
          fails++;
          $display("FAIL zw_first: instr=%h pc=%h want %h/0", instr_ID, pc_ID, word_of(32'h0));
        end
      end
    end
    @(negedge clk); keep_PC = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL zw_drain: pending=%0d req=%b want 0/0", sb.size(), imem_req);
    end
  endtask

  task automatic test_delayed();
    logic [31:0] base;
    int n;
    n = 0;
    @(negedge clk); mem_delay = 3; keep_PC = 1'b0; base = model_pc;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      if (valid_ID === 1'b1) begin
        tests++;
        if (pc_ID !== base + 32'(4 * n)) begin
          fails++;
          $display("FAIL dly_pc: pc=%h want %h", pc_ID, base + 32'(4 * n));
        end
        n++;
      end
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL dly_count: valid cycles=%0d want 4", n);
    end
    @(negedge clk); keep_PC = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL dly_drain: pending=%0d req=%b want 0/0", sb.size(), imem_req);
    end
  endtask

  task automatic test_stall_buffer();
    logic [31:0] a;
    @(negedge clk); mem_delay = 0; keep_PC = 1'b0; keep_instr = 1'b0; a = model_pc;
    @(negedge clk);
    @(negedge clk); keep_PC = 1'b1; keep_instr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++;
      if (instr_ID !== word_of(a) || pc_ID !== a || valid_ID !== 1'b1 || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold: instr=%h pc=%h valid=%b req=%b want %h/%h/1/0",
                 instr_ID, pc_ID, valid_ID, imem_req, word_of(a), a);
      end
    end
    tests++;
    if (stall_cnt !== 16'd2) begin
      fails++;
      $display("FAIL stall_cnt: got %0d want 2", stall_cnt);
    end
    @(negedge clk); keep_PC = 1'b0; keep_instr = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (instr_ID !== word_of(a + 32'd4) || pc_ID !== a + 32'd4 || valid_ID !== 1'b1 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: instr=%h pc=%h valid=%b req=%b want %h/%h/1/0",
               instr_ID, pc_ID, valid_ID, imem_req, word_of(a + 32'd4), a + 32'd4);
    end
    @(negedge clk); keep_PC = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL stall_drain: pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_redirect();
    @(negedge clk); mem_delay = 2; keep_PC = 1'b0; keep_instr = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(negedge clk); redirect_valid = 1'b0;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      fails++;
      $display("FAIL redir_pending: req=%b addr=%h want 1/00000020", imem_req, imem_addr);
    end
    @(negedge clk); redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_ID !== NOP || valid_ID !== 1'b0) begin
      fails++;
      $display("FAIL redir_target: req=%b addr=%h instr=%h valid=%b want 1/00000100/%h/0",
               imem_req, imem_addr, instr_ID, valid_ID, NOP);
    end
    repeat (3) @(negedge clk);
    keep_PC = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (instr_ID !== word_of(32'h100) || pc_ID !== 32'h100 || valid_ID !== 1'b1) begin
      fails++;
      $display("FAIL redir_land: instr=%h pc=%h valid=%b want %h/00000100/1", instr_ID, pc_ID, valid_ID, word_of(32'h100));
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL redir_drain: pending=%0d req=%b want 0/0", sb.size(), imem_req);
    end
  endtask

  task automatic test_redirect_flush();
    @(negedge clk); mem_delay = 0; keep_PC = 1'b0; keep_instr = 1'b0;
    @(negedge clk);
    @(negedge clk); keep_PC = 1'b1; keep_instr = 1'b1;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    tests++;
    if (instr_ID !== NOP || valid_ID !== 1'b0 || stall_cnt !== 16'd4) begin
      fails++;
      $display("FAIL flush_nop: instr=%h valid=%b cnt=%0d want %h/0/4", instr_ID, valid_ID, stall_cnt, NOP);
    end
    @(negedge clk); redirect_valid = 1'b0; keep_instr = 1'b0; keep_PC = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (instr_ID !== NOP || valid_ID !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      fails++;
      $display("FAIL flush_resume: instr=%h valid=%b req=%b addr=%h want %h/0/1/00000200",
               instr_ID, valid_ID, imem_req, imem_addr, NOP);
    end
    @(negedge clk); keep_PC = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (instr_ID !== word_of(32'h200) || pc_ID !== 32'h200 || valid_ID !== 1'b1) begin
      fails++;
      $display("FAIL flush_land: instr=%h pc=%h valid=%b want %h/00000200/1", instr_ID, pc_ID, valid_ID, word_of(32'h200));
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL flush_drain: pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_saturate_and_reset();
    logic [31:0] b;
    @(negedge clk); mem_delay = 0; keep_PC = 1'b0; keep_instr = 1'b0; b = model_pc;
    @(negedge clk); keep_PC = 1'b1;
    @(negedge clk); keep_instr = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    tests++;
    if (stall_cnt !== 16'hFFFF || valid_ID !== 1'b1 || instr_ID !== word_of(b)) begin
      fails++;
      $display("FAIL sat_cnt: cnt=%h valid=%b instr=%h want FFFF/1/%h", stall_cnt, valid_ID, instr_ID, word_of(b));
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (stall_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL sat_hold: cnt=%h want FFFF", stall_cnt);
    end
    @(negedge clk); keep_instr = 1'b0; keep_PC = 1'b0; man_en = 1'b1; man_ack = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== b + 32'd4) begin
      fails++;
      $display("FAIL rst_setup: req=%b addr=%h want 1/%h", imem_req, imem_addr, b + 32'd4);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_ID !== NOP || pc_ID !== 32'h0 ||
        valid_ID !== 1'b0 || stall_cnt !== 16'h0) begin
      fails++;
      $display("FAIL rst_midwait: req=%b addr=%h instr=%h pc=%h valid=%b cnt=%h want reset values",
               imem_req, imem_addr, instr_ID, pc_ID, valid_ID, stall_cnt);
    end
    @(negedge clk); rst = 1'b0; keep_PC = 1'b1; man_ack = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (imem_req !== 1'b0 || instr_ID !== NOP || valid_ID !== 1'b0 || pc_ID !== 32'h0) begin
      fails++;
      $display("FAIL stray_ack: req=%b instr=%h valid=%b pc=%h want 0/%h/0/0", imem_req, instr_ID, valid_ID, pc_ID, NOP);
    end
    @(negedge clk); man_en = 1'b0; man_ack = 1'b0; keep_PC = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_refetch: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
    @(negedge clk); keep_PC = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (instr_ID !== word_of(32'h0) || pc_ID !== 32'h0 || valid_ID !== 1'b1) begin
      fails++;
      $display("FAIL rst_land: instr=%h pc=%h valid=%b want %h/0/1", instr_ID, pc_ID, valid_ID, word_of(32'h0));
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL rst_drain: pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; keep_PC = 1'b0; keep_instr = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    model_pc = 32'h0; model_drop = 1'b0; mem_delay = 0; wait_cnt = 0;
    man_en = 1'b0; man_ack = 1'b0;
    fork
      model_loop();
    join_none
    test_reset();
    test_zero_wait();
    test_delayed();
    test_stall_buffer();
    test_redirect();
    test_redirect_flush();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
